tau_alu: RTL and testbench

Single-cycle arithmetic/logic unit of the tau processor datapath, parameterised by word width. Produces a combinational result from two operands and a 4-bit operation code, and maintains a registered status-flag byte (zero, sign, carry, overflow) that later instructions (ADC, SBB) consume. Sits between the register-file read ports and the writeback path; the flag byte feeds branch/condition logic.

---
 rtl/tau_alu.sv | 148 ++++++++++++++
 tb/tb_tau_alu.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tau_alu.sv
// tau datapath ALU: combinational result plus a registered Z/S/CF/V flag byte.
// ADC/SBB consume the CF captured at the previous clock edge.
module tau_alu #(
   parameter int WORD_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] input_A,
   input  logic [WORD_SIZE-1:0] input_B,
   input  logic [3:0]           mode_select,
   output logic [WORD_SIZE-1:0] output_C,
   output logic [7:0]           flags
);

   localparam int W = WORD_SIZE;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,  OP_MOV   = 4'd1,  OP_CMP   = 4'd2,  OP_TEST  = 4'd3,
      OP_SHL   = 4'd4,  OP_SHR   = 4'd5,  OP_ADD   = 4'd6,  OP_ADC   = 4'd7,
      OP_SUB   = 4'd8,  OP_SBB   = 4'd9,  OP_MUL   = 4'd10, OP_AND   = 4'd11,
      OP_OR    = 4'd12, OP_XOR   = 4'd13, OP_NOT   = 4'd14, OP_CLEAR = 4'd15
   } op_t;

   op_t            op;
   logic           carry_flag;
   logic           carry_in;
   logic           borrow_in;
   logic [W:0]     sum;
   logic [W:0]     diff;
   logic [W:0]     shl;
   logic [W:0]     shr;
   logic [2*W-1:0] prod;
   logic [W-1:0]   result;
   logic [W-1:0]   zs_src;
   logic           cf_next;
   logic           v_next;
   logic           update;
   logic           clear;
   logic [7:0]     flags_next;

   assign op         = op_t'(mode_select);
   assign carry_flag = flags[5];
   assign carry_in   = (op == OP_ADC) & carry_flag;
   assign borrow_in  = (op == OP_SBB) & carry_flag;

   // All carry/borrow arithmetic is done one bit wider so the top bit is CF.
   assign sum  = {1'b0, input_A} + {1'b0, input_B} + {{W{1'b0}}, carry_in};
   assign diff = {1'b0, input_A} - {1'b0, input_B} - {{W{1'b0}}, borrow_in};
   assign prod = {{W{1'b0}}, input_A} * {{W{1'b0}}, input_B};

   // The extra bit catches the last bit shifted out; oversized shifts give all zeros.
   assign shl = {1'b0, input_A} << input_B;
   assign shr = {input_A, 1'b0} >> input_B;

   always_comb begin
      result  = '0;
      zs_src  = '0;
      cf_next = 1'b0;
      v_next  = 1'b0;
      update  = 1'b1;
      clear   = 1'b0;
      case (op)
         OP_NOP: begin
            update = 1'b0;
         end
         OP_MOV: begin
            result = input_B;
            update = 1'b0;
         end
         OP_CMP: begin
            result  = input_A;
            zs_src  = diff[W-1:0];
            cf_next = diff[W];
            v_next  = (input_A[W-1] != input_B[W-1]) && (diff[W-1] != input_A[W-1]);
         end
         OP_TEST: begin
            result = input_A;
            zs_src = input_A & input_B;
         end
         OP_SHL: begin
            result  = shl[W-1:0];
            zs_src  = shl[W-1:0];
            cf_next = shl[W];
         end
         OP_SHR: begin
            result  = shr[W:1];
            zs_src  = shr[W:1];
            cf_next = shr[0];
         end
         OP_ADD, OP_ADC: begin
            result  = sum[W-1:0];
            zs_src  = sum[W-1:0];
            cf_next = sum[W];
            v_next  = (input_A[W-1] == input_B[W-1]) && (sum[W-1] != input_A[W-1]);
         end
         OP_SUB, OP_SBB: begin
            result  = diff[W-1:0];
            zs_src  = diff[W-1:0];
            cf_next = diff[W];
            v_next  = (input_A[W-1] != input_B[W-1]) && (diff[W-1] != input_A[W-1]);
         end
         OP_MUL: begin
            result  = prod[W-1:0];
            zs_src  = prod[W-1:0];
            cf_next = |prod[2*W-1:W];
            v_next  = |prod[2*W-1:W];
         end
         OP_AND: begin
            result = input_A & input_B;
            zs_src = input_A & input_B;
         end
         OP_OR: begin
            result = input_A | input_B;
            zs_src = input_A | input_B;
         end
         OP_XOR: begin
            result = input_A ^ input_B;
            zs_src = input_A ^ input_B;
         end
         OP_NOT: begin
            result = ~input_A;
            zs_src = ~input_A;
         end
         OP_CLEAR: begin
            clear = 1'b1;
         end
         default: begin
            update = 1'b0;
         end
      endcase
   end

   always_comb begin
      flags_next = 8'h00;
      if (!clear)
         flags_next = {(zs_src == '0), zs_src[W-1], cf_next, v_next, 4'b0000};
   end

   assign output_C = result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flags <= 8'h00;
      else if (update)
         flags <= flags_next;
   end

endmodule

// File: tb/tb_tau_alu.sv
// Directed-vector bench for tau_alu (WORD_SIZE = 8): checks the combinational
// result in-cycle and the flag byte just after the capturing edge.
module tb_tau_alu;

   localparam int W = 8;

   localparam logic [3:0] NOP = 4'd0,  MOV = 4'd1,  CMP = 4'd2,  TEST = 4'd3;
   localparam logic [3:0] SHL = 4'd4,  SHR = 4'd5,  ADD = 4'd6,  ADC  = 4'd7;
   localparam logic [3:0] SUB = 4'd8,  SBB = 4'd9,  MUL = 4'd10, AND_ = 4'd11;
   localparam logic [3:0] OR_ = 4'd12, XOR_ = 4'd13, NOT_ = 4'd14, CLR = 4'd15;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] input_A;
   logic [W-1:0] input_B;
   logic [3:0]   mode_select;
   logic [W-1:0] output_C;
   logic [7:0]   flags;

   int checks;
   int errors;

   tau_alu #(.WORD_SIZE(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_A     (input_A),
      .input_B     (input_B),
      .mode_select (mode_select),
      .output_C    (output_C),
      .flags       (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one operation just after an edge, check C in-cycle, then flags after the next edge.
   task automatic do_op(input string tag, input logic [3:0] mode, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_c, input logic [7:0] exp_f);
      mode_select = mode;
      input_A     = a;
      input_B     = b;
      #1;
      check_eq({tag, ".C"}, 32'(output_C), 32'(exp_c));
      @(posedge clk);
      #1;
      check_eq({tag, ".F"}, 32'(flags), 32'(exp_f));
      $display("op %-10s mode=%0d A=0x%02h B=0x%02h C=0x%02h flags=0x%02h",
               tag, mode, a, b, output_C, flags);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      input_A     = '0;
      input_B     = '0;
      mode_select = ADD;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset.F", 32'(flags), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Add / carry chaining
      do_op("add10_30",  ADD,  8'd10,  8'd30,  8'd40,  8'h00);
      do_op("add255_1",  ADD,  8'd255, 8'd1,   8'd0,   8'hA0);
      do_op("adc1_0",    ADC,  8'd1,   8'd0,   8'd2,   8'h00);
      do_op("add2_ff",   ADD,  8'd2,   8'hFF,  8'd1,   8'h20);
      do_op("clear",     CLR,  8'h55,  8'hAA,  8'd0,   8'h00);
      do_op("add127_1",  ADD,  8'd127, 8'd1,   8'd128, 8'h50);

      // Shifts including B = 0, B = WORD_SIZE and B > WORD_SIZE
      do_op("shl2_6",    SHL,  8'd2,   8'd6,   8'd128, 8'h40);
      do_op("shl128_1",  SHL,  8'd128, 8'd1,   8'd0,   8'hA0);
      do_op("shl_b0",    SHL,  8'h81,  8'd0,   8'h81,  8'h40);
      do_op("shl_b8",    SHL,  8'h01,  8'd8,   8'h00,  8'hA0);
      do_op("shl_b9",    SHL,  8'hFF,  8'd9,   8'h00,  8'h80);
      do_op("shr81_1",   SHR,  8'h81,  8'd1,   8'h40,  8'h20);
      do_op("shr_b8",    SHR,  8'h80,  8'd8,   8'h00,  8'hA0);
      do_op("shr_b0",    SHR,  8'h03,  8'd0,   8'h03,  8'h00);

      // Logic ops and TEST
      do_op("and",       AND_, 8'h6B,  8'hDF,  8'h4B,  8'h00);
      do_op("or",        OR_,  8'h6B,  8'h90,  8'hFB,  8'h40);
      do_op("xor",       XOR_, 8'hAA,  8'hAA,  8'h00,  8'h80);
      do_op("not",       NOT_, 8'h0F,  8'h3C,  8'hF0,  8'h40);
      do_op("test_ff",   TEST, 8'hFF,  8'hFF,  8'hFF,  8'h40);
      do_op("test_zero", TEST, 8'hF0,  8'h0F,  8'hF0,  8'h80);

      // Compare / subtract with borrow
      do_op("cmp3_4",    CMP,  8'd3,   8'd4,   8'd3,   8'h60);
      do_op("cmp4_3",    CMP,  8'd4,   8'd3,   8'd4,   8'h00);
      do_op("setcf",     ADD,  8'd255, 8'd1,   8'd0,   8'hA0);
      do_op("sbb10_3",   SBB,  8'd10,  8'd3,   8'd6,   8'h00);
      do_op("sub80_1",   SUB,  8'h80,  8'd1,   8'h7F,  8'h10);
      do_op("sub0_1",    SUB,  8'd0,   8'd1,   8'hFF,  8'h60);
      do_op("sbb10_5",   SBB,  8'h10,  8'h05,  8'h0A,  8'h00);

      // Multiply, then flag-holding ops
      do_op("mul16_16",  MUL,  8'd16,  8'd16,  8'd0,   8'hB0);
      do_op("mul15_17",  MUL,  8'd15,  8'd17,  8'hFF,  8'h40);
      do_op("mov",       MOV,  8'h12,  8'h33,  8'h33,  8'h40);
      do_op("nop",       NOP,  8'h12,  8'h33,  8'h00,  8'h40);

      // Asynchronous reset mid-cycle: flags clear without an edge, ADC sees CF = 0
      do_op("setcf2",    ADD,  8'd255, 8'd1,   8'd0,   8'hA0);
      #2;
      rst_n       = 1'b0;
      mode_select = ADC;
      input_A     = 8'd1;
      input_B     = 8'd0;
      #1;
      check_eq("async_rst.F", 32'(flags), 32'h00);
      check_eq("async_rst.C", 32'(output_C), 32'd1);
      @(posedge clk);
      #1;
      check_eq("rst_hold.F", 32'(flags), 32'h00);
      $display("op %-10s rst_n=0 C=0x%02h flags=0x%02h", "async_rst", output_C, flags);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_rst.F", 32'(flags), 32'h00);
      do_op("post_rst",  ADD,  8'd255, 8'd1,   8'd0,   8'hA0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
